// File: rtl/debounce_pulse.sv
// Multi-channel switch/button conditioner: sync, debounce, edge pulses, optional auto-repeat.
// Repeat phase per channel:  PH_DELAY | waiting REPEAT_DLY after the rise
//                            PH_PERIOD | emitting every REPEAT_PER cycles
module debounce_pulse #(
  parameter int N          = 8,
  parameter int DB_CYCLES  = 16,
  parameter int EDGE_MODE  = 0,
  parameter int REPEAT_DLY = 0,
  parameter int REPEAT_PER = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] pulse
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DB_CYCLES - 1);
  localparam bit REP_EN = (REPEAT_DLY > 0) && (REPEAT_PER >= 1) && (EDGE_MODE != 1);

  typedef enum logic {
    PH_DELAY  = 1'b0,
    PH_PERIOD = 1'b1
  } ph_t;

  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [N-1:0]  level_d;
  logic [CW-1:0] cnt [N];
  logic [N-1:0]  edge_src;
  logic [N-1:0]  rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s1      <= din;
      s2      <= s1;
      level_d <= level;
      for (int i = 0; i < N; i++) begin
        if (s2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TC) begin
          level[i] <= s2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

  always_comb begin
    edge_src = rise | fall;
    case (EDGE_MODE)
      0:       edge_src = rise;
      1:       edge_src = fall;
      default: edge_src = rise | fall;
    endcase
  end

  generate
    if (REP_EN) begin : g_rep
      localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
      localparam int RW   = $clog2(RMAX) + 1;
      localparam logic [RW-1:0] DLY_TC = RW'(REPEAT_DLY - 1);
      localparam logic [RW-1:0] PER_TC = RW'(REPEAT_PER - 1);

      ph_t          ph     [N];
      ph_t          ph_nxt [N];
      logic [RW-1:0] rc     [N];
      logic [RW-1:0] rc_nxt [N];
      logic [N-1:0]  rp_q;
      logic [N-1:0]  rp_nxt;

      // rc is held at 0 while level is low, so it already starts from 0 in the
      // rise cycle and counts that cycle; the first repeat lands REPEAT_DLY after rise.
      always_comb begin
        rp_nxt = '0;
        for (int i = 0; i < N; i++) begin
          ph_nxt[i] = ph[i];
          rc_nxt[i] = rc[i];
          if (!level[i]) begin
            ph_nxt[i] = PH_DELAY;
            rc_nxt[i] = '0;
          end else if (ph[i] == PH_DELAY && rc[i] == DLY_TC) begin
            rp_nxt[i] = 1'b1;
            ph_nxt[i] = PH_PERIOD;
            rc_nxt[i] = '0;
          end else if (ph[i] == PH_PERIOD && rc[i] == PER_TC) begin
            rp_nxt[i] = 1'b1;
            rc_nxt[i] = '0;
          end else begin
            rc_nxt[i] = rc[i] + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rp_q <= '0;
          for (int i = 0; i < N; i++) begin
            ph[i] <= PH_DELAY;
            rc[i] <= '0;
          end
        end else begin
          rp_q <= rp_nxt;
          for (int i = 0; i < N; i++) begin
            ph[i] <= ph_nxt[i];
            rc[i] <= rc_nxt[i];
          end
        end
      end

      assign rp = rp_q;
    end else begin : g_no_rep
      assign rp = '0;
    end
  endgenerate

  // Masking with level kills a repeat pulse registered on the same edge level fell.
  assign pulse = edge_src | (rp & level);

endmodule
